// File: rtl/des_key_sched_pkg.sv
// Shared DES key-schedule tables, FSM state type and the C/D rotate helper.
package des_key_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  // PC-1 source bit for each of the 56 C/D bits, 1-based with bit 1 = key MSB
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:56] pc1(input logic [1:64] key);
    logic [63:0] k;
    logic [55:0] r;
    k = key;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TBL[6'(i)])];
    end
    return r;
  endfunction

  function automatic logic [1:28] rot28(input logic [1:28] v, input logic [1:0] amt,
                                        input logic right);
    logic [1:28] r;
    case ({right, amt})
      3'b001:  r = {v[2:28], v[1]};
      3'b010:  r = {v[3:28], v[1:2]};
      3'b101:  r = {v[28], v[1:27]};
      3'b110:  r = {v[27:28], v[1:26]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Start/key request and subkey valid/ready handshake between sequencer, datapath and key schedule.
interface des_key_sched_if;
  logic        start;
  logic        decrypt;
  logic [1:64] key;
  logic        abort;
  logic [1:48] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        key_err;

  modport master (
    output start, decrypt, key, abort, subkey_ready,
    input  subkey, subkey_valid, round_idx, busy, done, key_err
  );

  modport slave (
    input  start, decrypt, key, abort, subkey_ready,
    output subkey, subkey_valid, round_idx, busy, done, key_err
  );
endinterface

// File: rtl/des_key_sched_pc2.sv
// DES PC-2 compression permutation: 56-bit C/D halves to a 48-bit round subkey.
module pc2 (
  input  logic [1:28] c,
  input  logic [1:28] d,
  output logic [1:48] k
);
  logic [1:56] cd;
  logic        unused_bits;

  assign cd = {c, d};

  assign k = {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
              cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
              cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
              cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
              cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
              cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
              cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
              cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};

  // PC-2 drops these eight positions
  assign unused_bits = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};
endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: PC-1 load, per-round C/D rotation, PC-2 subkey with valid/ready.
// Optional key byte parity check: DES_KEY_SCHED_PARITY_CHK_EN.
module des_key_sched
  import des_key_pkg::*;
#(
  parameter int unsigned NROUNDS = 16
) (
  input logic            clk,
  input logic            rst,
  des_key_sched_if.slave bus
);
  state_t      state, state_nxt;
  logic [1:28] c, d;
  logic        dec_r;
  logic [3:0]  round_idx_r;
  logic [1:56] cd0;
  logic [1:48] subkey_w;
  logic        parity_ok;
  logic        last, load, hs;
  logic [1:0]  next_amt;

  assign cd0  = pc1(bus.key);
  assign last = (round_idx_r == 4'(NROUNDS - 1));
  assign load = (state == S_IDLE) && bus.start && parity_ok && !bus.abort;
  assign hs   = (state == S_ROUND) && bus.subkey_ready && !bus.abort;

`ifdef DES_KEY_SCHED_PARITY_CHK_EN
  logic key_err_r;

  assign parity_ok = (^bus.key[1:8])   & (^bus.key[9:16])  & (^bus.key[17:24]) &
                     (^bus.key[25:32]) & (^bus.key[33:40]) & (^bus.key[41:48]) &
                     (^bus.key[49:56]) & (^bus.key[57:64]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_err_r <= 1'b0;
    end else if ((state == S_IDLE) && bus.start && !bus.abort) begin
      key_err_r <= !parity_ok;
    end
  end

  assign bus.key_err = key_err_r;
`else
  assign parity_ok   = 1'b1;
  assign bus.key_err = 1'b0;
`endif

  // The final decrypt step rotates right once more so C/D land back on C0D0,
  // matching encrypt whose 16 shifts already total 28.
  always_comb begin
    next_amt = 2'd0;
    if (last) begin
      next_amt = dec_r ? ENC_SHIFT[0] : 2'd0;
    end else if (dec_r) begin
      next_amt = DEC_SHIFT[round_idx_r + 4'd1];
    end else begin
      next_amt = ENC_SHIFT[round_idx_r + 4'd1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (load) state_nxt = S_ROUND;
      S_ROUND: if (hs && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c           <= '0;
      d           <= '0;
      dec_r       <= 1'b0;
      round_idx_r <= '0;
    end else if (bus.abort) begin
      round_idx_r <= '0;
    end else if (load) begin
      c           <= rot28(cd0[1:28], bus.decrypt ? DEC_SHIFT[0] : ENC_SHIFT[0], bus.decrypt);
      d           <= rot28(cd0[29:56], bus.decrypt ? DEC_SHIFT[0] : ENC_SHIFT[0], bus.decrypt);
      dec_r       <= bus.decrypt;
      round_idx_r <= '0;
    end else if (hs) begin
      c           <= rot28(c, next_amt, dec_r);
      d           <= rot28(d, next_amt, dec_r);
      round_idx_r <= last ? 4'd0 : round_idx_r + 4'd1;
    end
  end

  pc2 u_pc2 (
    .c(c),
    .d(d),
    .k(subkey_w)
  );

  assign bus.subkey       = subkey_w;
  assign bus.subkey_valid = (state == S_ROUND);
  assign bus.busy         = (state == S_ROUND);
  assign bus.done         = (state == S_DONE);
  assign bus.round_idx    = round_idx_r;
endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched with a subkey scoreboard fed at start and drained on handshakes.
module tb_des_key_sched;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  des_key_sched_if bus ();

  des_key_sched #(.NROUNDS(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
  localparam logic [63:0] BADKEY = 64'h123457799BBCDFF1;
  localparam logic [47:0] K16    = 48'hCB3D8B0E17F5;

  logic [47:0] ek [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [63:0] k, input logic dec, output time t0);
    bus.key     = k;
    bus.decrypt = dec;
    bus.start   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sb.push_back('{dec ? ek[15 - i] : ek[i], 4'(i)});
    end
    tick();
    bus.start = 1'b0;
    t0 = $time;
  endtask

  // Latency counts clock edges from the start edge up to and including the done edge
  task automatic wait_done(input time t0, output int lat);
    int n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    lat = int'(($time - t0) / 10) + 1;
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n = 0;
    while (bus.round_idx !== idx && n < 100) begin
      tick();
      n++;
    end
    check("wait_round_idx", 64'(bus.round_idx), 64'(idx));
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.subkey_valid === 1'b1 && bus.subkey_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_subkey", 64'(bus.subkey), 64'(e.sk));
        check("sb_round_idx", 64'(bus.round_idx), 64'(e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    time t0;
    int  lat;

    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.decrypt      = 1'b0;
    bus.key          = '0;
    bus.abort        = 1'b0;
    bus.subkey_ready = 1'b1;
    tick();
    tick();
    check("rst_subkey", 64'(bus.subkey), 64'd0);
    check("rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_round_idx", 64'(bus.round_idx), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_key_err", 64'(bus.key_err), 64'd0);
    rst = 1'b0;
    tick();

    // Encrypt
    start_run(KEY, 1'b0, t0);
    check("enc_first_valid", 64'(bus.subkey_valid), 64'd1);
    check("enc_busy", 64'(bus.busy), 64'd1);
    check("enc_k1", 64'(bus.subkey), 64'(ek[0]));
    wait_done(t0, lat);
    check("enc_latency", 64'(lat), 64'd17);
    check("enc_done", 64'(bus.done), 64'd1);
    check("enc_done_valid", 64'(bus.subkey_valid), 64'd0);
    check("enc_done_busy", 64'(bus.busy), 64'd0);
    check("enc_done_idx", 64'(bus.round_idx), 64'd0);
    check("enc_cd_restored", 64'(bus.subkey), 64'(K16));
    tick();
    check("enc_done_pulse", 64'(bus.done), 64'd0);
    check("enc_sb_drained", 64'(sb.size()), 64'd0);

    // Decrypt, plus a start presented during the DONE cycle
    start_run(KEY, 1'b1, t0);
    check("dec_k16_first", 64'(bus.subkey), 64'(K16));
    wait_done(t0, lat);
    check("dec_latency", 64'(lat), 64'd17);
    check("dec_cd_restored", 64'(bus.subkey), 64'(K16));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_in_done_ignored", 64'(bus.busy), 64'd0);
    check("dec_done_pulse", 64'(bus.done), 64'd0);
    check("dec_sb_drained", 64'(sb.size()), 64'd0);

    // Backpressure at round 5
    start_run(KEY, 1'b0, t0);
    wait_idx(4'd4);
    bus.subkey_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_subkey", 64'(bus.subkey), 64'(ek[4]));
      check("bp_round_idx", 64'(bus.round_idx), 64'd4);
      check("bp_valid", 64'(bus.subkey_valid), 64'd1);
    end
    bus.subkey_ready = 1'b1;
    wait_done(t0, lat);
    check("bp_latency", 64'(lat), 64'd20);
    tick();
    check("bp_sb_drained", 64'(sb.size()), 64'd0);

    // Abort at round 7 with a same-cycle handshake, then restart
    start_run(KEY, 1'b0, t0);
    wait_idx(4'd6);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_valid", 64'(bus.subkey_valid), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_round_idx", 64'(bus.round_idx), 64'd0);
    check("abort_cd_retained", 64'(bus.subkey), 64'(ek[6]));
    sb.delete();
    start_run(KEY, 1'b0, t0);
    check("restart_k1", 64'(bus.subkey), 64'(ek[0]));
    wait_done(t0, lat);
    check("restart_latency", 64'(lat), 64'd17);
    tick();

    // Asynchronous reset at round 3
    start_run(KEY, 1'b0, t0);
    wait_idx(4'd2);
    #3 rst = 1'b1;
    #1;
    check("async_rst_subkey", 64'(bus.subkey), 64'd0);
    check("async_rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_round_idx", 64'(bus.round_idx), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();

    // Start during ROUND must not disturb the running schedule
    start_run(KEY, 1'b0, t0);
    wait_idx(4'd2);
    bus.start   = 1'b1;
    bus.decrypt = 1'b1;
    bus.key     = 64'h0123456789ABCDEF;
    tick();
    bus.start = 1'b0;
    check("busy_start_idx", 64'(bus.round_idx), 64'd3);
    check("busy_start_subkey", 64'(bus.subkey), 64'(ek[3]));
    wait_done(t0, lat);
    check("busy_start_latency", 64'(lat), 64'd17);
    check("busy_start_cd", 64'(bus.subkey), 64'(K16));
    tick();

`ifdef DES_KEY_SCHED_PARITY_CHK_EN
    bus.key   = BADKEY;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("par_key_err", 64'(bus.key_err), 64'd1);
    check("par_busy", 64'(bus.busy), 64'd0);
    tick();
    check("par_key_err_held", 64'(bus.key_err), 64'd1);
    check("par_busy_held", 64'(bus.busy), 64'd0);
    start_run(KEY, 1'b0, t0);
    check("par_key_err_cleared", 64'(bus.key_err), 64'd0);
    check("par_good_busy", 64'(bus.busy), 64'd1);
    wait_done(t0, lat);
    check("par_good_latency", 64'(lat), 64'd17);
    tick();
`else
    bus.subkey_ready = 1'b0;
    bus.key          = BADKEY;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check("nopar_key_err", 64'(bus.key_err), 64'd0);
    check("nopar_busy", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort        = 1'b0;
    bus.subkey_ready = 1'b1;
    check("nopar_abort_busy", 64'(bus.busy), 64'd0);
    tick();
`endif

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES key-schedule controller for the TDES core.
- Takes a 64-bit key, applies PC-1, and steps the C/D halves through 16 rounds, rotating left for encrypt and right for decrypt.
- Presents one 48-bit round subkey per round through the pc2 compression permutation, with a valid/ready handshake to the round datapath.
- One instance per TDES key stage; the TDES sequencer starts each instance with its own key and direction.

Parameters:
- NROUNDS, 16, number of rounds (fixed at 16 for DES; the parameter exists only so tests can shorten runs).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; accepted only while busy=0.
- decrypt  in  1  direction, sampled with start (0=encrypt, 1=decrypt).
- key  in  [1:64]  DES key, bit 1 = MSB, sampled with start.
- abort  in  1  synchronous cancel of the current schedule.
- subkey  out  [1:48]  current round subkey, pc2(C,D).
- subkey_valid  out  1  subkey is valid for round round_idx.
- subkey_ready  in  1  datapath consumes the subkey.
- round_idx  out  4  current round minus 1 (0..15).
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse after round 16 is consumed.
- key_err  out  1  parity failure (only with the optional feature).

Behaviour:
- Reset values: state=IDLE, C/D=0, subkey_valid=0, round_idx=0, busy=0, done=0, key_err=0. subkey is pc2 of the zero register, i.e. 0.
- IDLE:
  - start=1 loads C/D = PC1(key) with the round-1 shift already applied. Encrypt shift is left 1; decrypt shift is 0.
  - The same cycle latches decrypt and moves to ROUND.
- ROUND:
  - subkey_valid=1 and busy=1; the first subkey_valid comes 1 cycle after start.
  - subkey is combinational pc2 of the C/D register and stays stable while subkey_valid=1 and subkey_ready=0.
  - On a valid&ready handshake with round_idx<NROUNDS-1: round_idx increments, and C and D each rotate by the next round's shift amount.
  - Encrypt shift table for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, rotating left.
  - Decrypt: round 1 shift 0; rounds 2, 9, 16 shift 1; all other rounds shift 2; rotating right.
  - On a handshake with round_idx=NROUNDS-1: go to DONE.
  - With subkey_ready held high, the 16 rounds take 16 cycles.
- DONE: done=1 for one cycle, subkey_valid=0, busy=0, round_idx=0; next state IDLE. A start in this cycle is ignored.
- abort=1 in any state: next state IDLE, subkey_valid=0, no done pulse, C/D retained. abort has priority over a same-cycle handshake.
- start while busy=1 is ignored and leaves key/direction unchanged.
- Cumulative rotation over the 16 rounds is 28, so C16D16 = C0D0. This must hold after round 16 in both directions.
- rst asserted mid-schedule: all outputs take their reset values immediately (asynchronous).

Optional Feature:
- Macro: DES_KEY_SCHED_PARITY_CHK_EN.
- Defined:
  - On start, every key byte must have odd parity.
  - On failure, start is refused: state stays IDLE and key_err=1 from the next cycle.
  - key_err is held until the next accepted start or rst.
- Undefined: parity bits are ignored and key_err is tied to 0.

Decomposition:
- Package des_key_pkg holds:
  - the PC1 index table (56 entries);
  - the encrypt shift table (16x2 bits);
  - the decrypt shift table;
  - the state enum (IDLE, ROUND, DONE).
- One sub-module: pc2, the existing 56->48 compression permutation, instantiated unchanged with c=C, d=D.
- The rotate function lives in the package.

Test Plan:
- Encrypt run:
  - Stimulus: key=133457799BBCDFF1, decrypt=0, subkey_ready=1.
  - Response: round_idx 0 subkey=1B02EFFC7072; round_idx 15 subkey=CB3D8B0E17F5; done pulses 17 cycles after start; C/D equal PC1(key).
- Decrypt run, same key:
  - Response: first subkey=CB3D8B0E17F5; last subkey=1B02EFFC7072; the 16 subkeys are the encrypt list reversed.
- Backpressure:
  - Stimulus: subkey_ready low for 3 cycles at round 5.
  - Response: subkey and round_idx stable; subkey_valid stays high; total latency is 20 cycles.
- Abort and restart:
  - Stimulus: abort at round 7, then a new start next cycle.
  - Response: no done pulse; the restarted schedule's first subkey matches a fresh run.
- Reset and busy start:
  - Stimulus: rst pulse at round 3; then start during ROUND.
  - Response: outputs go to 0 immediately on rst; a start during ROUND is ignored.
- With DES_KEY_SCHED_PARITY_CHK_EN:
  - Stimulus: key=123457799BBCDFF1.
  - Response: key_err=1; busy stays 0; next valid start clears key_err.
